// File: rtl/pipeline_param_v.sv
// pipeline_param_v: parametrised ID/EX/WB ALU pipeline with valid/ready
// issue, full EX->ID and WB->ID forwarding and an optional iterative MUL.
// Ports: clk, rst (sync, active high), __START__ (global step enable),
// inst/inst_valid/inst_ready (issue handshake), busy (MUL in progress),
// dummy_read_rf/dummy_rf_data (combinational register-file debug read).
// Macro PIPE_MUL_EN: op 111 becomes a DW-cycle shift-add multiply that
// stalls issue; when undefined op 111 is a NOP and busy is tied low.
module pipeline_param_v #(
  parameter  int DW   = 8,
  parameter  int NREG = 4,
  localparam int RW   = $clog2(NREG),
  localparam int IW   = 3 + 3*RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          __START__,
  input  logic [IW-1:0] inst,
  input  logic          inst_valid,
  output logic          inst_ready,
  output logic          busy,
  input  logic [RW-1:0] dummy_read_rf,
  output logic [DW-1:0] dummy_rf_data
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_LI  = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  logic [DW-1:0]   registers [NREG];

  op_e             id_op;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [2*RW-1:0] id_imm;
  logic            id_wen;
  logic [DW-1:0]   opa;
  logic [DW-1:0]   opb;

  op_e             id_ex_op;
  logic [DW-1:0]   id_ex_a;
  logic [DW-1:0]   id_ex_b;
  logic [RW-1:0]   id_ex_rd;
  logic            id_ex_wen;

  logic [DW-1:0]   ex_res;
  logic [DW-1:0]   mul_res;
  logic            ex_fwd;

  logic [DW-1:0]   ex_wb_val;
  logic [RW-1:0]   ex_wb_rd;
  logic            ex_wb_wen;

  assign id_op  = op_e'(inst[IW-1 -: 3]);
  assign id_rs1 = inst[3*RW-1 -: RW];
  assign id_rs2 = inst[2*RW-1 -: RW];
  assign id_rd  = inst[RW-1:0];
  assign id_imm = {id_rs1, id_rs2};

`ifdef PIPE_MUL_EN
  assign id_wen = (id_op != OP_NOP);
`else
  assign id_wen = (id_op != OP_NOP) && (id_op != OP_MUL);
`endif

  // EX result only counts once it is final (MUL on its last cycle)
  assign ex_fwd = id_ex_wen && !busy;

  // EX beats WB beats the register file
  always_comb begin
    opa = registers[id_rs1];
    opb = registers[id_rs2];
    if (ex_wb_wen && ex_wb_rd == id_rs1) opa = ex_wb_val;
    if (ex_wb_wen && ex_wb_rd == id_rs2) opb = ex_wb_val;
    if (ex_fwd && id_ex_rd == id_rs1) opa = ex_res;
    if (ex_fwd && id_ex_rd == id_rs2) opb = ex_res;
  end

  always_comb begin
    ex_res = '0;
    case (id_ex_op)
      OP_ADD:  ex_res = id_ex_a + id_ex_b;
      OP_SUB:  ex_res = id_ex_a - id_ex_b;
      OP_AND:  ex_res = id_ex_a & id_ex_b;
      OP_OR:   ex_res = id_ex_a | id_ex_b;
      OP_XOR:  ex_res = id_ex_a ^ id_ex_b;
      OP_LI:   ex_res = id_ex_a;
      OP_MUL:  ex_res = mul_res;
      default: ex_res = '0;
    endcase
  end

`ifdef PIPE_MUL_EN
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW-1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] term;
  logic          mul_act;

  assign mul_act = id_ex_wen && (id_ex_op == OP_MUL);
  assign term    = id_ex_b[cnt] ? (id_ex_a << cnt) : '0;
  // last partial product is folded in combinationally on the final cycle
  assign mul_res = acc + term;
  assign busy    = mul_act && (cnt != LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (__START__) begin
      if (busy) begin
        cnt <= cnt + 1'b1;
        acc <= mul_res;
      end else begin
        cnt <= '0;
        acc <= '0;
      end
    end
  end
`else
  assign busy    = 1'b0;
  assign mul_res = '0;
`endif

  assign inst_ready    = !rst && __START__ && !busy;
  assign dummy_rf_data = registers[dummy_read_rf];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) registers[i] <= '0;
      id_ex_op  <= OP_NOP;
      id_ex_a   <= '0;
      id_ex_b   <= '0;
      id_ex_rd  <= '0;
      id_ex_wen <= 1'b0;
      ex_wb_val <= '0;
      ex_wb_rd  <= '0;
      ex_wb_wen <= 1'b0;
    end else if (__START__) begin
      if (ex_wb_wen) registers[ex_wb_rd] <= ex_wb_val;
      if (busy) begin
        ex_wb_wen <= 1'b0;
      end else begin
        ex_wb_val <= ex_res;
        ex_wb_rd  <= id_ex_rd;
        ex_wb_wen <= id_ex_wen;
        id_ex_op  <= inst_valid ? id_op : OP_NOP;
        id_ex_wen <= inst_valid && id_wen;
        id_ex_a   <= (id_op == OP_LI) ? DW'(id_imm) : opa;
        id_ex_b   <= opb;
        id_ex_rd  <= id_rd;
      end
    end
  end

endmodule

// File: doc/pipeline_param_v.md
# pipeline_param_v

Parametrised successor to the 4-register, 8-bit, 3-stage (ID/EX/WB) pipelined ALU core. It generalises data width and register count and replaces the free-running instruction input with a valid/ready handshake. It adds OR/XOR, a load-immediate and an optional iterative multi-cycle multiply that stalls the front end. Full EX→ID and WB→ID forwarding is kept, so no instruction sequence needs software NOPs. The block sits at the same level as the existing core and is a verification target for ILA refinement checks.

## Interface
- `DW`, 8: datapath and register width; must satisfy `DW >= 2*RW`.
- `NREG`, 4: number of architectural registers, power of two ≥ 2.
- `RW`, derived `$clog2(NREG)`: register index width (localparam).
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `__START__`  in  1  global step enable; when low, all state holds.
- `inst`  in  3+3*RW  `{op[2:0], rs1, rs2, rd}`, MSB first.
- `inst_valid`  in  1  `inst` is presented.
- `inst_ready`  out  1  ID accepts `inst` this cycle.
- `busy`  out  1  EX is occupied by an unfinished MUL.
- `dummy_read_rf`  in  RW  register file debug read index.
- `dummy_rf_data`  out  DW  combinational `registers[dummy_read_rf]`.

## Operation
- Opcodes:
  - 000 NOP.
  - 001 ADD, rd=rs1+rs2.
  - 010 SUB, rd=rs1−rs2.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 LI, rd = zero-extended `{rs1,rs2}` (2*RW-bit immediate).
  - 111 MUL, rd = low DW bits of rs1*rs2.
- All arithmetic is modulo 2^DW. Results never extend into a carry bit.
- Write enable: every op except NOP writes rd. Under the macro-off configuration, 111 also does not write.
- Handshake: `inst_ready = !rst && __START__ && !busy`. An instruction is accepted on a cycle with `inst_valid && inst_ready`.
- On a ready cycle with `inst_valid` low, a bubble (NOP, wen=0) enters EX.
- ID operand select per source, in priority order:
  1. EX result, if the EX instruction writes the matching rd.
  2. `ex_wb_val`, if the WB stage writes the matching rd.
  3. Register file.
- A forwarded value overrides a register-file value even when WB writes the same register that edge.
- EX for single-cycle ops: combinational result, registered into WB the next edge.
- EX for MUL: an iterative shift-add unit with counter `cnt`, 0..DW-1, occupying EX for exactly DW cycles.
  - `busy` is high on the first DW-1 of those cycles.
  - On the final cycle `busy` is low and the result is valid for forwarding and for WB capture.
  - While `busy`, the ID→EX register holds and WB receives a bubble each cycle.
- WB: on a posedge with `__START__`, if `ex_wb_wen`, then `registers[ex_wb_rd] <= ex_wb_val`.

## Timing
- Reset values:
  - All registers 0.
  - `id_ex_wen`, `ex_wb_wen` 0.
  - `cnt` 0.
  - `busy` 0.
  - `inst_ready` 0 while `rst` is high.
  - `dummy_rf_data` 0.
- Latency: an instruction accepted at edge k has its result in `registers` after edge k+2. With MUL it is after edge k+DW+1.
- Dependent back-to-back instructions issue every cycle with no stall. Only MUL stalls, for DW-1 cycles.
- `__START__` low: every register, `cnt` and the pipeline hold; `inst_ready` is 0.
- `rst` mid-MUL: the MUL is aborted, `cnt` cleared, the pipeline drained to bubbles. `inst_ready` rises on the first cycle with `rst` low.
- MUL with rs1 or rs2 forwarded from a preceding instruction captures the forwarded operand at acceptance.

## Configuration
- `PIPE_MUL_EN` defined:
  - Op 111 is MUL as described.
  - The multiplier, `cnt` and `busy` logic are present.
- `PIPE_MUL_EN` undefined:
  - Op 111 behaves as NOP, with no write and no stall.
  - `busy` is tied 0 and no multiplier logic is synthesised.

## Test plan
All scenarios use DW=8, NREG=4.
- LI r1,5; LI r2,3; ADD r3,r1,r2, issued back-to-back -> `dummy_rf_data` for r3 reads 8, two cycles after ADD acceptance; `inst_ready` is never low.
- From the state above, SUB r0,r2,r1 -> r0 = 0xFE (wrap); then AND/OR/XOR r0,r1,r2 -> 1, 7, 6.
- `PIPE_MUL_EN` on, MUL r3,r1,r2 then ADD r0,r3,r1 -> `busy` high for 7 cycles, `inst_ready` low for 7 cycles, r3=15, r0=20 via EX forwarding.
- `__START__` low for 3 cycles with `inst_valid` high mid-stream -> no register, pipeline or `dummy_rf_data` change; `inst_ready`=0; stream resumes with correct results.
- `rst` pulsed on the 4th cycle of a MUL -> all registers 0, `busy` 0, no write of the aborted MUL; `inst_ready`=1 on the first cycle after `rst` drops.
- `PIPE_MUL_EN` off, op 111 with rd=r1 holding 5 -> r1 stays 5, `busy`=0, `inst_ready` stays high.
